// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: Wishbone bundle around the shared-bus arbiter.
//   Parameters: NM masters, AW address bits, DW data bits.
//   Master side: m_adr_i/m_dat_i/m_we_i/m_stb_i/m_cyc_i (packed, master k in slice k),
//     m_dat_o (broadcast read data), m_ack_o/m_err_o (per master), gnt_o (one-hot grant).
//   Slave side: s_adr_o/s_dat_o/s_we_o/s_stb_o/s_cyc_o toward the slave, s_dat_i/s_ack_i back.
//   Modport master: the arbiter's view (it masters the shared slave bus).
//   Modport slave: the view of whatever surrounds it (requesting masters and the slave).
interface wb_arbiter_if #(
   parameter int NM = 2,
   parameter int AW = 12,
   parameter int DW = 16
);
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM-1:0]    m_we_i;
   logic [NM-1:0]    m_stb_i;
   logic [NM-1:0]    m_cyc_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [DW-1:0]    s_dat_i;
   logic             s_we_o;
   logic             s_stb_o;
   logic             s_cyc_o;
   logic             s_ack_i;
   logic [NM-1:0]    gnt_o;
   modport master (
      input  m_adr_i, m_dat_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o, gnt_o
   );
   modport slave (
      output m_adr_i, m_dat_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o, gnt_o
   );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone slave bus among NM masters.
//   Ports: clk_i (rising-edge clock), rst_i (async active-high reset),
//          bus (wb_arbiter_if.master: all master- and slave-side Wishbone signals).
//   Parameters: NM masters (2..8), AW/DW address/data widths, TO_CYC watchdog limit.
//   Optional feature: define WB_ARB_TIMEOUT_EN to enable the no-ack watchdog,
//   which pulses m_err_o to the granted master and drops s_stb_o for that cycle.
//   Without it m_err_o is tied low and a hung slave stalls the bus.
module wb_arbiter #(
   parameter int NM     = 2,
   parameter int AW     = 12,
   parameter int DW     = 16,
   parameter int TO_CYC = 255
) (
   input logic          clk_i,
   input logic          rst_i,
   wb_arbiter_if.master bus
);
   localparam int IW = $clog2(NM);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUS  = 1'b1;
   logic [0:0]    state;
   logic [IW-1:0] g;
   logic [IW-1:0] last;
   logic [IW-1:0] pick;
   logic [NM-1:0] gnt;
   logic          in_bus;
   logic          cyc_g;
   logic          stb_g;
   logic          to_hit;
   // Scan from last+NM down to last+1 so the nearest requester after last wins.
   always_comb begin
      pick = last;
      for (int i = NM; i >= 1; i--)
         if (bus.m_cyc_i[(int'(last) + i) % NM]) pick = IW'((int'(last) + i) % NM);
   end
   assign in_bus = state == BUS;
   assign cyc_g  = in_bus & bus.m_cyc_i[g];
   assign stb_g  = cyc_g & bus.m_stb_i[g];
`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   // An ack in the limit cycle wins: no error and the strobe is left alone.
   assign to_hit = stb_g & ~bus.s_ack_i & (cnt == 16'(TO_CYC));
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt <= '0;
      else       cnt <= (stb_g & ~bus.s_ack_i & ~to_hit) ? cnt + 16'd1 : '0;
   assign bus.m_err_o = to_hit ? gnt : '0;
`else
   assign to_hit      = 1'b0;
   assign bus.m_err_o = '0;
`endif
   assign bus.s_adr_o = in_bus ? bus.m_adr_i[g*AW +: AW] : '0;
   assign bus.s_dat_o = in_bus ? bus.m_dat_i[g*DW +: DW] : '0;
   assign bus.s_we_o  = in_bus & bus.m_we_i[g];
   assign bus.s_cyc_o = cyc_g;
   assign bus.s_stb_o = stb_g & ~to_hit;
   assign bus.m_dat_o = bus.s_dat_i;
   // Ack only reaches a master that still holds cyc, so late acks after an abort vanish.
   assign bus.m_ack_o = (cyc_g & bus.s_ack_i) ? gnt : '0;
   assign bus.gnt_o   = gnt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state <= IDLE;
         gnt   <= '0;
         g     <= '0;
         last  <= IW'(NM - 1);
      end else if (state == IDLE) begin
         if (|bus.m_cyc_i) begin
            state <= BUS;
            gnt   <= NM'(1) << pick;
            g     <= pick;
            last  <= pick;
         end
      end else if (!bus.m_cyc_i[g]) begin
         state <= IDLE;
         gnt   <= '0;
      end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter (NM=2, AW=12, DW=16, TO_CYC=8).
module tb_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];
   wb_arbiter_if #(.NM(2), .AW(12), .DW(16)) bus ();
   wb_arbiter #(.NM(2), .AW(12), .DW(16), .TO_CYC(8)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.master)
   );
   always #5 clk = ~clk;
   task automatic push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask
   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic exp_err;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_we_i  = '0;
      bus.m_stb_i = '0;
      bus.m_cyc_i = 2'b11;
      bus.s_dat_i = '0;
      bus.s_ack_i = 1'b0;
      #12;
      push("rst_gnt", 32'h0);   pop_chk(32'(bus.gnt_o));
      push("rst_scyc", 32'h0);  pop_chk(32'(bus.s_cyc_o));
      push("rst_ack", 32'h0);   pop_chk(32'(bus.m_ack_o));
      @(negedge clk);
      rst = 1'b0;
      tick();
      push("first_gnt", 32'h1); pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b00;
      tick();
      push("rel_gnt", 32'h0);   pop_chk(32'(bus.gnt_o));
      // single write from master 0
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b01;
      bus.m_adr_i[11:0] = 12'h00E; bus.m_dat_i[15:0] = 16'hFFFF;
      tick();
      push("wr_gnt", 32'h1);    pop_chk(32'(bus.gnt_o));
      push("wr_adr", 32'h00E);  pop_chk(32'(bus.s_adr_o));
      push("wr_dat", 32'hFFFF); pop_chk(32'(bus.s_dat_o));
      push("wr_we", 32'h1);     pop_chk(32'(bus.s_we_o));
      push("wr_stb", 32'h1);    pop_chk(32'(bus.s_stb_o));
      bus.s_ack_i = 1'b1;
      #1;
      push("wr_ack", 32'h1);    pop_chk(32'(bus.m_ack_o));
      tick();
      bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.m_we_i = 2'b00;
      tick();
      // read from master 1
      bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10; bus.m_adr_i[23:12] = 12'h10E;
      tick();
      push("rd_gnt", 32'h2);    pop_chk(32'(bus.gnt_o));
      push("rd_adr", 32'h10E);  pop_chk(32'(bus.s_adr_o));
      push("rd_we", 32'h0);     pop_chk(32'(bus.s_we_o));
      bus.s_dat_i = 16'hABCD; bus.s_ack_i = 1'b1;
      #1;
      push("rd_dat", 32'hABCD); pop_chk(32'(bus.m_dat_o));
      push("rd_ack", 32'h2);    pop_chk(32'(bus.m_ack_o));
      tick();
      bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      tick();
      push("rd_rel", 32'h0);    pop_chk(32'(bus.gnt_o));
      // contention: last granted is m1, so m0 wins first, then strict rotation
      bus.m_cyc_i = 2'b11;
      tick();
      push("ct_g0", 32'h1);     pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b10;
      tick();
      push("ct_idle0", 32'h0);  pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b11;
      tick();
      push("ct_g1", 32'h2);     pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b01;
      tick();
      push("ct_idle1", 32'h0);  pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b11;
      tick();
      push("ct_g2", 32'h1);     pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b00;
      tick();
      // abort: m0 drops cyc with stb pending
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
      tick();
      push("ab_gnt", 32'h1);    pop_chk(32'(bus.gnt_o));
      push("ab_scyc1", 32'h1);  pop_chk(32'(bus.s_cyc_o));
      bus.m_cyc_i = 2'b00;
      #1;
      push("ab_scyc0", 32'h0);  pop_chk(32'(bus.s_cyc_o));
      push("ab_sstb0", 32'h0);  pop_chk(32'(bus.s_stb_o));
      bus.s_ack_i = 1'b1;
      #1;
      push("ab_ack_same", 32'h0); pop_chk(32'(bus.m_ack_o));
      tick();
      push("ab_rel", 32'h0);    pop_chk(32'(bus.gnt_o));
      push("ab_ack_late", 32'h0); pop_chk(32'(bus.m_ack_o));
      bus.s_ack_i = 1'b0; bus.m_stb_i = 2'b00;
      // watchdog: m1 strobes with no ack
      bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10;
      tick();
      for (int k = 0; k <= 12; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
         exp_err = (k == 8);
`else
         exp_err = 1'b0;
`endif
         push($sformatf("to_err_%0d", k), exp_err ? 32'h2 : 32'h0);
         pop_chk(32'(bus.m_err_o));
         push($sformatf("to_stb_%0d", k), 32'(!exp_err));
         pop_chk(32'(bus.s_stb_o));
         tick();
      end
      push("to_gnt_held", 32'h2); pop_chk(32'(bus.gnt_o));
      bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      tick();
      push("to_rel", 32'h0);    pop_chk(32'(bus.gnt_o));
      if (sb.size() != 0) begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
